// File: rtl/pipe_pkg.sv
// Shared pipeline types: M-extension operation encoding (funct3 order) and
// the multiply/divide unit state enum.
package pipe_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: LSB-first shift-add for
// multiply, restoring shift-subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    // Remainder after a successful subtract is below the divisor, so XLEN bits suffice.
    diff   = rem_sh[XLEN-1:0] - opb_i;
    if (is_div_i) begin
      if (rem_sh >= {1'b0, opb_i}) acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
      else                         acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (IDLE/CALC/DONE).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply path.
module muldiv_unit
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  muldiv_op_t      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  muldiv_op_t        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc;

  logic              accept, sa_in, sb_in, b_zero, ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Apply result sign and pick the half / quotient / remainder the op wants.
  function automatic logic [XLEN-1:0] finish_res(input muldiv_op_t op, input logic [2*XLEN-1:0] acc,
                                                input logic sa, input logic sb);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = (sa ^ sb) ? -acc : acc;
    quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:                      return prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             return quo;
      default:                     return rem;
    endcase
  endfunction

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (step_acc)
  );

  assign ready_o  = (state_q == MD_IDLE) || (state_q == MD_DONE);
  assign busy_o   = (state_q == MD_CALC);
  assign done_o   = (state_q == MD_DONE);
  assign result_o = result_q;

  always_comb begin
    accept = start_i && ready_o && !flush_i;
    sa_in  = a_i[XLEN-1] && (op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM);
    sb_in  = b_i[XLEN-1] && (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
    a_mag  = sa_in ? -a_i : a_i;
    b_mag  = sb_in ? -b_i : b_i;
    b_zero = op_is_div(op_i) && (b_i == '0);
    ovf    = (op_i == OP_DIV || op_i == OP_REM) && (a_i == MOST_NEG) && (b_i == '1);
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opb_d    = opb_q;
    acc_d    = acc_q;

    case (state_q)
      MD_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = MD_DONE;
          cnt_d    = '0;
          result_d = finish_res(op_q, step_acc, sa_q, sb_q);
        end
      end
      default: begin
        state_d = MD_IDLE;
        if (accept) begin
          op_d  = op_i;
          sa_d  = sa_in;
          sb_d  = sb_in;
          cnt_d = '0;
          if (b_zero) begin
            state_d  = MD_DONE;
            result_d = op_i[1] ? a_i : '1;
          end else if (ovf) begin
            state_d  = MD_DONE;
            result_d = op_i[1] ? '0 : MOST_NEG;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op_is_div(op_i)) begin
            state_d  = MD_DONE;
            result_d = finish_res(op_i, fast_prod, sa_in, sb_in);
`endif
          end else begin
            state_d = MD_CALC;
            acc_d   = op_is_div(op_i) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            opb_d   = op_is_div(op_i) ? b_mag : a_mag;
          end
        end
      end
    endcase

    // Abort wins over everything, including a same-cycle request.
    if (flush_i) begin
      state_d  = MD_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    opb_q <= opb_d;
    acc_q <= acc_d;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32), both multiply build options.
module tb_muldiv_unit;
  import pipe_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  muldiv_op_t  op_i = OP_MUL;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o, busy_o, done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input muldiv_op_t op, input bit special);
    if (special || (FAST && !op[2])) return 1;
    return 33;
  endfunction

  // Drives a request now, then scrambles the inputs and waits for done_o.
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = muldiv_op_t'(3'($urandom));
    lat = 1;
    while (!done_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
  endtask

  initial begin
    logic [31:0] res, saved;
    int lat, dones;

    vecs.push_back('{OP_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_neg"});
    vecs.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max"});
    vecs.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 1'b0, "mulhsu"});
    vecs.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, "mulh_m1m1"});
    vecs.push_back('{OP_MULH,   32'h80000000, 32'h2,        32'hFFFFFFFF, 1'b0, "mulh_min2"});
    vecs.push_back('{OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, "div_m7_2"});
    vecs.push_back('{OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, "rem_m7_2"});
    vecs.push_back('{OP_DIVU,   32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7"});
    vecs.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7"});
    vecs.push_back('{OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, "div_100_m7"});
    vecs.push_back('{OP_REM,    32'd100,      32'hFFFFFFF9, 32'd2,        1'b0, "rem_100_m7"});
    vecs.push_back('{OP_DIVU,   32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b0, "divu_max_1"});
    vecs.push_back('{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0"});
    vecs.push_back('{OP_REM,    32'd5,        32'd0,        32'd5,        1'b1, "rem_by0"});
    vecs.push_back('{OP_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1'b1, "div_by0"});
    vecs.push_back('{OP_REMU,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b1, "remu_by0"});
    vecs.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf"});
    vecs.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1, "rem_ovf"});

    // Reset state
    #12;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, "_res"}, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_lat(vecs[i].op, vecs[i].special)));
      @(posedge clk); #1;
      check({vecs[i].name, "_pulse"}, 32'(done_o), 32'd0);
      check({vecs[i].name, "_hold"}, result_o, vecs[i].exp);
    end

    // Back-to-back: DIV accepted in the done_o cycle of a MUL
    run_op(OP_MUL, 32'h7, 32'hFFFFFFFD, res, lat);
    check("b2b_mul_res", res, 32'hFFFFFFEB);
    check("b2b_ready_in_done", 32'(ready_o), 32'd1);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, res, lat);
    check("b2b_div_res", res, 32'hFFFFFFFD);
    check("b2b_div_lat", 32'(lat), 32'd33);
    @(posedge clk); #1;

    // Flush in CALC cycle 10
    saved = result_o;
    op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("flush_busy_before", 32'(busy_o), 32'd1);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_ready", 32'(ready_o), 32'd1);
    check("flush_busy", 32'(busy_o), 32'd0);
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done_o) dones++; end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_result_kept", result_o, saved);

    // Flush and start together: request dropped
    op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("fs_busy", 32'(busy_o), 32'd0);
    dones = 0;
    repeat (40) begin @(posedge clk); #1; if (done_o) dones++; end
    check("fs_no_done", 32'(dones), 32'd0);
    check("fs_result_kept", result_o, saved);

    // Async reset mid-CALC
    op_i = OP_MUL; a_i = 32'd7; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst_ready", 32'(ready_o), 32'd1);
    check("mrst_busy", 32'(busy_o), 32'd0);
    check("mrst_done", 32'(done_o), 32'd0);
    check("mrst_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OP_DIVU, 32'd9, 32'd3, res, lat);
    check("post_rst_divu", res, 32'd3);
    check("post_rst_lat", 32'(lat), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
